// File: rtl/shift_sequencer.sv
// Control FSM for the parallel-load shifter: load, shift N cycles, stream the outgoing bits, and pulse completion.
// Optional rotate mode is enabled with `define SHIFT_SEQ_ROTATE_EN (adds rotate_i).
module shift_sequencer #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 dir_i,
  input  logic [CNT_WIDTH-1:0] count_i,
  input  logic                 fill_i,
  input  logic                 abort_i,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic                 rotate_i,
`endif
  input  logic [BUS_WIDTH-1:0] shift_q_i,
  output logic                 select1_o,
  output logic                 select2_o,
  output logic                 dataR_o,
  output logic                 dataL_o,
  output logic                 ready_o,
  output logic                 ser_o,
  output logic                 ser_valid_o,
  output logic                 done_o,
  output logic                 aborted_o
);

  localparam int IDX_W = $clog2(BUS_WIDTH);
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(BUS_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, next_state;
  logic [CNT_WIDTH-1:0] cnt, next_cnt;
  logic                 dir, next_dir;
  logic                 fill, next_fill;
  logic                 data_r, data_l;
  logic                 next_sel1, next_sel2, next_data_r, next_data_l;
  logic                 next_ready, next_ser_valid, next_done, next_aborted;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_bit;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic                 rot, next_rot;
`endif

  // Next-state and command capture
  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_dir     = dir;
    next_fill    = fill;
    next_aborted = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    next_rot     = rot;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
          next_state = LOAD;
          next_dir   = dir_i;
          next_fill  = fill_i;
          next_cnt   = (count_i > MAX_CNT) ? MAX_CNT : count_i;
`ifdef SHIFT_SEQ_ROTATE_EN
          next_rot   = rotate_i;
`endif
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        if (abort_i) begin
          next_state   = IDLE;
          next_aborted = 1'b1;
          next_cnt     = '0;
        end else if (cnt != '0) begin
          next_state = SHIFT;
        end else begin
          next_state = DONE;
        end
      end
      SHIFT: begin
        if (abort_i) begin
          next_state   = IDLE;
          next_aborted = 1'b1;
          next_cnt     = '0;
        end else begin
          next_cnt   = cnt - CNT_WIDTH'(1);
          next_state = (cnt == CNT_WIDTH'(1)) ? DONE : SHIFT;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // Registered outputs are a pure function of the state being entered
  always_comb begin
    next_sel1      = 1'b0;
    next_sel2      = 1'b0;
    next_data_r    = 1'b0;
    next_data_l    = 1'b0;
    next_ready     = 1'b0;
    next_ser_valid = 1'b0;
    next_done      = 1'b0;
    case (next_state)
      IDLE:  next_ready = 1'b1;
      LOAD:  next_sel2  = 1'b1;
      SHIFT: begin
        next_sel1      = 1'b1;
        next_sel2      = next_dir;
        next_ser_valid = 1'b1;
        next_data_l    = next_dir & next_fill;
        next_data_r    = ~next_dir & next_fill;
      end
      DONE:    next_done  = 1'b1;
      default: next_ready = 1'b1;
    endcase
  end

  // State, command and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dir         <= 1'b0;
      fill        <= 1'b0;
      select1_o   <= 1'b0;
      select2_o   <= 1'b0;
      data_r      <= 1'b0;
      data_l      <= 1'b0;
      ready_o     <= 1'b1;
      ser_valid_o <= 1'b0;
      done_o      <= 1'b0;
      aborted_o   <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot         <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      dir         <= next_dir;
      fill        <= next_fill;
      select1_o   <= next_sel1;
      select2_o   <= next_sel2;
      data_r      <= next_data_r;
      data_l      <= next_data_l;
      ready_o     <= next_ready;
      ser_valid_o <= next_ser_valid;
      done_o      <= next_done;
      aborted_o   <= next_aborted;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot         <= next_rot;
`endif
    end
  end

  // The outgoing bit only exists in the shifter during the shifting cycle,
  // so it is taken straight from shift_q_i and gated by the registered valid.
  assign out_idx = dir ? '0 : IDX_W'(BUS_WIDTH - 1);
  assign out_bit = shift_q_i[out_idx];
  assign ser_o   = ser_valid_o & out_bit;

`ifdef SHIFT_SEQ_ROTATE_EN
  assign dataR_o = rot ? (ser_valid_o & ~dir & out_bit) : data_r;
  assign dataL_o = rot ? (ser_valid_o & dir & out_bit) : data_l;
`else
  assign dataR_o = data_r;
  assign dataL_o = data_l;
`endif

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Control FSM for the 8-bit parallel-load shifter.
- Accepts a shift command: direction, shift count and fill bit.
- Drives the shifter's two mode selects and its serial-in bits for the commanded number of cycles, then signals completion.
- Samples the shifter's register output to stream out the shifted bits. Sits directly beside the shifter and shares its clock.

Parameters:
- BUS_WIDTH, 8, width of the controlled shifter word.
- CNT_WIDTH, 4, width of count_i; must satisfy 2^CNT_WIDTH > BUS_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  command strobe; accepted only while ready_o=1.
- dir_i  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB).
- count_i  input  CNT_WIDTH  number of shift cycles requested.
- fill_i  input  1  bit shifted into the vacated end.
- abort_i  input  1  cancels an operation in LOAD or SHIFT.
- shift_q_i  input  BUS_WIDTH  current shifter register output.
- select1_o  output  1  shifter mode select, MSB of mode.
- select2_o  output  1  shifter mode select, LSB of mode.
- dataR_o  output  1  serial bit into shifter bit 0 during left shift.
- dataL_o  output  1  serial bit into shifter bit BUS_WIDTH-1 during right shift.
- ready_o  output  1  idle, can accept start_i.
- ser_o  output  1  bit leaving the shifter this cycle.
- ser_valid_o  output  1  ser_o valid.
- done_o  output  1  one-cycle completion pulse.
- aborted_o  output  1  one-cycle abort pulse.

Behaviour:
- Mode encoding {select1_o,select2_o}:
  - 00 hold
  - 01 parallel load
  - 10 shift left; dataR_o enters bit 0
  - 11 shift right; dataL_o enters bit BUS_WIDTH-1
- Reset (asynchronous, immediate, including mid-operation):
  - state=IDLE, mode=00, dataR_o=dataL_o=0, ready_o=1.
  - ser_o=ser_valid_o=done_o=aborted_o=0; internal counter=0.
- All outputs are registered.
- FSM states:
  - IDLE: mode 00, ready_o=1. start_i=1 at an edge captures dir_i, fill_i, and count=min(count_i, BUS_WIDTH) → LOAD. start_i outside IDLE is ignored.
  - LOAD: one cycle, mode 01, ready_o=0. → SHIFT if count>0, else → DONE.
  - SHIFT: mode 10 (dir=0) or 11 (dir=1).
    - Serial bit for the selected direction = fill; the unused serial output stays 0.
    - ser_valid_o=1; ser_o=shift_q_i[BUS_WIDTH-1] (left) or shift_q_i[0] (right), i.e. the bit being shifted out on that edge.
    - Counter decrements each cycle. Exactly count SHIFT cycles, then → DONE.
  - DONE: mode 00, done_o=1 for exactly one cycle → IDLE (ready_o=1 next cycle).
- Latency: start accepted at edge k → LOAD cycle k+1 → SHIFT cycles k+2..k+1+N → done_o during cycle k+2+N.
  - N=8: 10 cycles from start to done. N=0: done in cycle k+2.
- Back-to-back: start_i held high is re-accepted on the first IDLE cycle after DONE.
- abort_i in LOAD or SHIFT:
  - Next edge: mode 00, aborted_o=1 for one cycle, no done_o, → IDLE.
  - Shifts already applied remain in the shifter.
  - abort_i in IDLE or DONE is ignored; DONE still completes normally.
- abort_i and start_i together in IDLE: start wins.
- count_i > BUS_WIDTH: clamped to BUS_WIDTH.

Optional Feature:
- Macro SHIFT_SEQ_ROTATE_EN.
- When defined:
  - Adds input rotate_i, captured with the command.
  - If rotate=1, the serial bit in SHIFT is the outgoing bit (shift_q_i[BUS_WIDTH-1] for left, shift_q_i[0] for right) instead of fill.
  - After BUS_WIDTH rotations the word is unchanged.
- When undefined: no rotate_i port; serial bit is always fill.

Test Plan:
- Reset mid-SHIFT (count 8, after 3 shifts), rst pulse → all outputs at reset values immediately, ready_o=1 after release.
- Shifter preloaded 8'hA5, start dir=0 count=3 fill=1 → ser_o stream 1,0,1; shifter 8'h2F; done_o exactly at cycle k+5.
- Shifter preloaded 8'hA5, start dir=1 count=8 fill=0 → ser_o stream 1,0,1,0,0,1,0,1; shifter 8'h00; done_o at cycle k+10.
- count_i=0 → one LOAD cycle, no ser_valid_o, done_o at k+2; count_i=15 → exactly 8 shift cycles.
- abort_i asserted in 2nd SHIFT cycle of count=6 → aborted_o pulse, no done_o, mode 00, ready_o=1 next cycle; start_i pulsed during SHIFT ignored.
- SHIFT_SEQ_ROTATE_EN defined, word 8'h81, rotate=1 dir=0 count=1 → shifter 8'h03; count=8 → shifter 8'h81.
